// File: rtl/ldpc_qc_enc_if.sv
// Stream and configuration bundle for the QC-LDPC encoder.
// The master side feeds info bits and generator rows and drains the codeword; the slave is the encoder.
interface ldpc_qc_enc_if #(
   parameter int R = 5,
   parameter int C = 3,
   parameter int D = 8
);
   localparam int AW = $clog2((R-C)*C);

   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [D-1:0]  cfg_data;
   logic          in_valid;
   logic          in_ready;
   logic          in_bit;
   logic          out_valid;
   logic          out_ready;
   logic          out_bit;
   logic          out_last;
   logic          busy;

   modport master (
      output cfg_we, cfg_addr, cfg_data, in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_bit, out_last, busy
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_bit, out_last, busy
   );
endinterface

// File: rtl/ldpc_qc_enc.sv
// Systematic QC-LDPC encoder: info bits pass through, then C*D parity bits from a rotating-row accumulator.
// Optional macro LDPC_ENC_PUNCT_EN suppresses emission of info block 0 (parity is unaffected).
//
// state  | meaning
// IDLE   | waiting for in_valid; generator rows writable
// INFO   | accepting info bits, accumulating parity, forwarding bits
// PARITY | draining P[0..C-1] LSB-first, out_last on the final bit
module ldpc_qc_enc #(
   parameter int R = 5,
   parameter int C = 3,
   parameter int D = 8
) (
   input logic         clk,
   input logic         rst,
   ldpc_qc_enc_if.slave bus
);
   localparam int NG = (R-C)*C;
   localparam int AW = $clog2(NG);
   localparam int TW = $clog2(D);
   localparam int BW = ((R-C) > 1) ? $clog2(R-C) : 1;
   localparam int CW = (C > 1) ? $clog2(C) : 1;

   typedef enum logic [1:0] {IDLE, INFO, PARITY} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] t, pt;
   logic [BW-1:0] b, ld_blk;
   logic [CW-1:0] pj;
   logic [D-1:0]  g     [NG];
   logic [D-1:0]  p     [C];
   logic [D-1:0]  w     [C];
   logic [D-1:0]  g_row [C];
   logic          out_valid_r, out_bit_r, out_last_r;
   logic          in_ready_c, busy_c, punct, accept, drain, last_in;

   // Generator rows survive reset on purpose; only IDLE writes are honoured.
   always_ff @(posedge clk) begin
      if (bus.cfg_we && state == IDLE)
         g[bus.cfg_addr] <= bus.cfg_data;
   end

   // Row source: block 0 when starting a frame, otherwise the next block at a wrap.
   always_comb begin
      ld_blk = '0;
      if (state == INFO && int'(b) < R-C-1)
         ld_blk = b + 1'b1;
      for (int j = 0; j < C; j++)
         g_row[j] = g[AW'(int'(ld_blk)*C + j)];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = INFO;
         INFO:    if (accept && last_in) state_nxt = PARITY;
         PARITY:  if (drain && out_last_r) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      punct = 1'b0;
`ifdef LDPC_ENC_PUNCT_EN
      punct = (state == INFO) && (b == '0);
`endif
      in_ready_c = (state == INFO) && (punct || !out_valid_r || bus.out_ready);
      accept     = in_ready_c && bus.in_valid;
      drain      = out_valid_r && bus.out_ready;
      last_in    = (b == BW'(R-C-1)) && (t == TW'(D-1));
      busy_c     = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t           <= '0;
         b           <= '0;
         pt          <= '0;
         pj          <= '0;
         out_valid_r <= 1'b0;
         out_bit_r   <= 1'b0;
         out_last_r  <= 1'b0;
         for (int j = 0; j < C; j++) begin
            p[j] <= '0;
            w[j] <= '0;
         end
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               t  <= '0;
               b  <= '0;
               pt <= '0;
               pj <= '0;
               for (int j = 0; j < C; j++) begin
                  p[j] <= '0;
                  w[j] <= g_row[j];
               end
            end
            INFO: begin
               if (accept) begin
                  for (int j = 0; j < C; j++) begin
                     if (bus.in_bit) p[j] <= p[j] ^ w[j];
                     w[j] <= (t == TW'(D-1)) ? g_row[j] : {w[j][D-2:0], w[j][D-1]};
                  end
                  if (t == TW'(D-1)) begin
                     t <= '0;
                     b <= b + 1'b1;
                  end else begin
                     t <= t + 1'b1;
                  end
               end
               if (accept && !punct) begin
                  out_bit_r   <= bus.in_bit;
                  out_valid_r <= 1'b1;
               end else if (drain) begin
                  out_valid_r <= 1'b0;
               end
            end
            PARITY: begin
               // The final bit carries out_last; once it drains nothing more is loaded.
               if ((!out_valid_r || bus.out_ready) && !out_last_r) begin
                  out_bit_r   <= p[pj][pt];
                  out_valid_r <= 1'b1;
                  out_last_r  <= (pj == CW'(C-1)) && (pt == TW'(D-1));
                  if (pt == TW'(D-1)) begin
                     pt <= '0;
                     pj <= pj + 1'b1;
                  end else begin
                     pt <= pt + 1'b1;
                  end
               end else if (drain) begin
                  out_valid_r <= 1'b0;
                  out_last_r  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_r;
   assign bus.out_bit   = out_bit_r;
   assign bus.out_last  = out_last_r;
   assign bus.busy      = busy_c;
endmodule

// File: tb/tb_ldpc_qc_enc.sv
// Bench for ldpc_qc_enc: scoreboard of expected codeword bits pushed as info bits are accepted.
// Parity expectations come from a direct matrix model of the circulant generator.
module tb_ldpc_qc_enc;
   localparam int R = 5, C = 3, D = 8;
   localparam int K = (R-C)*D, N = R*D, NG = (R-C)*C;
   localparam int AW = $clog2(NG);
`ifdef LDPC_ENC_PUNCT_EN
   localparam int SKIP = D;
`else
   localparam int SKIP = 0;
`endif
   localparam int LEN = N - SKIP;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ldpc_qc_enc_if #(.R(R), .C(C), .D(D)) bus();
   ldpc_qc_enc #(.R(R), .C(C), .D(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;
   logic [D-1:0] gm [NG];
   logic [1:0]   exp_q [$];
   logic [D-1:0] obs_par [C];
   int           n_out;
   int           last_cyc;

   function automatic logic [D-1:0] model_par(input int j, input logic [K-1:0] u);
      logic [D-1:0] r = '0;
      logic [D-1:0] row;
      for (int k = 0; k < K; k++) begin
         row = gm[(k/D)*C + j];
         if (u[k])
            for (int i = 0; i < D; i++)
               r[i] = r[i] ^ row[(i - (k%D) + D) % D];
      end
      return r;
   endfunction

   task automatic cfg_write(input int a, input logic [D-1:0] d);
      bus.cfg_we = 1'b1; bus.cfg_addr = AW'(a); bus.cfg_data = d;
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
      gm[a] = d;
   endtask

   task automatic run_frame(input logic [K-1:0] u, input int mode, input int abort_at, input bit poke);
      int k = 0;
      int cyc;
      int pi;
      bit done = 1'b0;
      bit poked = 1'b0;
      bit in_acc, out_acc;
      logic prev_stall = 1'b0, prev_bit = 1'b0;
      logic [1:0] cur, e;
      logic [D-1:0] pv;
      n_out = 0;
      last_cyc = -1;
      exp_q.delete();
      for (cyc = 0; cyc < 4*N+20 && !done; cyc++) begin
         bus.out_ready = (mode == 1) ? cyc[0] : 1'b1;
         bus.in_valid  = (k < K);
         bus.in_bit    = (k < K) ? u[k] : 1'b0;
         if (poke && !poked && k == 5) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_data = ~gm[0];
            poked = 1'b1;
         end
         #1;
         if (prev_stall) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_bit !== prev_bit) begin
               fails++;
               $display("FAIL stall_hold cyc %0d: valid=%b bit=%b, expected valid=1 bit=%b",
                        cyc, bus.out_valid, bus.out_bit, prev_bit);
            end
         end
         in_acc     = bus.in_valid && bus.in_ready;
         out_acc    = bus.out_valid && bus.out_ready;
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_bit   = bus.out_bit;
         cur        = {bus.out_bit, bus.out_last};
         @(posedge clk); #1;
         bus.cfg_we = 1'b0;
         if (in_acc) begin
            if (k >= SKIP) exp_q.push_back({u[k], 1'b0});
            if (k == K-1)
               for (int j = 0; j < C; j++) begin
                  pv = model_par(j, u);
                  for (int i = 0; i < D; i++)
                     exp_q.push_back({pv[i], (j == C-1 && i == D-1) ? 1'b1 : 1'b0});
               end
            k++;
         end
         if (out_acc) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL stream[%0d]: extra output bit=%b last=%b", n_out, cur[1], cur[0]);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  fails++;
                  $display("FAIL stream[%0d]: got bit/last %b, expected %b", n_out, cur, e);
               end
            end
            pi = n_out - (K - SKIP);
            if (pi >= 0 && pi < C*D) obs_par[pi/D][pi%D] = cur[1];
            n_out++;
            if (cur[0]) begin
               done = 1'b1;
               last_cyc = cyc;
            end
         end
         if (abort_at > 0 && k == abort_at && !done) begin
            rst = 1'b1; bus.in_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            exp_q.delete();
            done = 1'b1;
         end
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         tests++; fails++;
         $display("FAIL frame_timeout: got %0d outputs, expected %0d", n_out, LEN);
      end
   endtask

   task automatic test_reset();
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
      bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last, bus.busy} !== 5'b0) begin
         fails++;
         $display("FAIL reset_outputs: got rdy/vld/bit/last/busy=%b, expected 00000",
                  {bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last, bus.busy});
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zeros();
      for (int a = 0; a < NG; a++) cfg_write(a, 8'h03);
      run_frame('0, 0, 0, 0);
      tests++;
      if (n_out !== LEN) begin
         fails++; $display("FAIL zeros_len: got %0d, expected %0d", n_out, LEN);
      end
      tests++;
      if ({obs_par[0], obs_par[1], obs_par[2]} !== 24'h0) begin
         fails++; $display("FAIL zeros_parity: got %h%h%h, expected 0", obs_par[0], obs_par[1], obs_par[2]);
      end
      @(posedge clk); #1;
      tests++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         fails++; $display("FAIL zeros_idle: got busy=%b valid=%b, expected 0 0", bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_single_bit();
      cfg_write(0, 8'h03); cfg_write(1, 8'h80); cfg_write(2, 8'h11);
      for (int a = 3; a < NG; a++) cfg_write(a, 8'h00);
      run_frame(K'(1), 0, 0, 0);
      tests++;
      if (obs_par[0] !== 8'h03 || obs_par[1] !== 8'h80 || obs_par[2] !== 8'h11) begin
         fails++; $display("FAIL single_bit: got %h %h %h, expected 03 80 11", obs_par[0], obs_par[1], obs_par[2]);
      end
   endtask

   task automatic test_rotation();
      run_frame(K'(1) << 3, 0, 0, 0);
      tests++;
      if (obs_par[0] !== 8'h18 || obs_par[1] !== 8'h04 || obs_par[2] !== 8'h88) begin
         fails++; $display("FAIL rotation_3: got %h %h %h, expected 18 04 88", obs_par[0], obs_par[1], obs_par[2]);
      end
      run_frame(K'(1) << 7, 0, 0, 0);
      tests++;
      if (obs_par[0] !== 8'h81) begin
         fails++; $display("FAIL rotation_wrap: got %h, expected 81", obs_par[0]);
      end
   endtask

   task automatic test_block_switch();
      cfg_write(3, 8'h0F);
      run_frame((K'(1) << 3) | (K'(1) << 8), 0, 0, 0);
      tests++;
      if (obs_par[0] !== 8'h17) begin
         fails++; $display("FAIL block_switch: got %h, expected 17", obs_par[0]);
      end
   endtask

   task automatic test_backpressure();
      for (int a = 0; a < NG; a++) cfg_write(a, D'($urandom));
      run_frame(K'($urandom), 1, 0, 0);
      tests++;
      if (n_out !== LEN) begin
         fails++; $display("FAIL backpressure_len: got %0d, expected %0d", n_out, LEN);
      end
   endtask

   task automatic test_reset_abort();
      logic [K-1:0] u = K'($urandom) | K'(1);
      logic [D-1:0] g0 = gm[0];
      run_frame(u, 0, 10, 1);
      tests++;
      if ({bus.in_ready, bus.out_valid, bus.out_last, bus.busy} !== 4'b0) begin
         fails++; $display("FAIL abort_outputs: got rdy/vld/last/busy=%b, expected 0000",
                           {bus.in_ready, bus.out_valid, bus.out_last, bus.busy});
      end
      @(posedge clk); #1;
      run_frame(u, 0, 0, 0);
      tests++;
      if (n_out !== LEN) begin
         fails++; $display("FAIL abort_next_len: got %0d, expected %0d", n_out, LEN);
      end
      tests++;
      if (gm[0] !== g0 || obs_par[0] !== model_par(0, u)) begin
         fails++; $display("FAIL abort_cfg_lock: got P0=%h, expected %h", obs_par[0], model_par(0, u));
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 2; f++) begin
         run_frame(K'($urandom), 0, 0, 0);
         tests++;
         if (last_cyc !== N+1) begin
            fails++; $display("FAIL throughput[%0d]: last bit at cycle %0d, expected %0d", f, last_cyc, N+1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zeros();
      test_single_bit();
      test_rotation();
      test_block_switch();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
